// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: fetch sequencer states and common constants.
package riscv_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP          = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_target_gen.sv
// Next-PC selection for the fetch unit: Jalr > Jump/branch > sequential.
// Only redirect targets can be misaligned; the sequential path never is.
module pc_target_gen
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic            jalr_i,
   input  logic            jump_i,
   input  logic            pc_src_i,
   output logic [XLEN-1:0] next_pc_o,
   output logic            misaligned_o
);

   logic [XLEN-1:0] jalr_sum;
   logic            redirect;

   assign jalr_sum = rs1_data_i + imm_i;

   // NOTE: every output gets a default first so no path through the
   // if/else chain can leave a variable unassigned and infer a latch.
   always_comb begin
      next_pc_o = pc_i + XLEN'(4);
      redirect  = 1'b0;
      if (jalr_i) begin
         next_pc_o = {jalr_sum[XLEN-1:1], 1'b0};
         redirect  = 1'b1;
      end else if (jump_i || pc_src_i) begin
         next_pc_o = pc_i + imm_i;
         redirect  = 1'b1;
      end
   end

   assign misaligned_o = redirect && (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: IDLE -> FETCH (req/ready) -> EXEC,
// forming the next PC on EXEC exit and redirecting misaligned targets to a trap vector.
module pc_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PC_Src,
   input  logic            Jump,
   input  logic            Jalr,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   output logic            instr_valid,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PC_plus4,
   output logic            misalign_trap,
   output logic [XLEN-1:0] trap_pc
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic            trap_q, trap_d;
   logic [XLEN-1:0] trap_pc_q, trap_pc_d;

   logic [XLEN-1:0] target_pc;
   logic            target_misaligned;

   pc_target_gen #(.XLEN(XLEN)) u_target (
      .pc_i         (pc_q),
      .imm_i        (imm),
      .rs1_data_i   (rs1_data),
      .jalr_i       (Jalr),
      .jump_i       (Jump),
      .pc_src_i     (PC_Src),
      .next_pc_o    (target_pc),
      .misaligned_o (target_misaligned)
   );

   // NOTE: state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_VECTOR;
         instr_q   <= NOP;
         trap_q    <= 1'b0;
         trap_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         trap_q    <= trap_d;
         trap_pc_q <= trap_pc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      trap_d    = 1'b0;
      trap_pc_d = trap_pc_q;
      unique case (state_q)
         IDLE: state_d = FETCH;  // a stale ack arriving here is dropped
         FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
               state_d = FETCH;
               if (target_misaligned) begin
                  pc_d      = TRAP_VECTOR;
                  trap_pc_d = pc_q;
                  trap_d    = 1'b1;
               end else begin
                  pc_d = target_pc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_req      = (state_q == FETCH);
   assign imem_addr     = pc_q;
   assign instr         = instr_q;
   assign instr_valid   = (state_q == EXEC);
   assign PC            = pc_q;
   assign PC_plus4      = pc_q + XLEN'(4);
   assign misalign_trap = trap_q;
   assign trap_pc       = trap_pc_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch sequencer for the RV32I core. It consumes PC_Src from branch_unit, plus the jump controls and immediate, to form the next PC. It fetches each instruction over a req/ready handshake to instruction memory and presents one instruction per execute slot to the datapath. It also flags misaligned control-flow targets and redirects them to a trap vector.

Parameters:
XLEN, 32, datapath/address width
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned target

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high
PC_Src  in  1  take-branch from branch_unit; sampled only in EXEC
Jump  in  1  JAL in current instruction
Jalr  in  1  JALR in current instruction
imm  in  XLEN  sign-extended immediate of current instruction
rs1_data  in  XLEN  rs1 value (JALR base)
stall  in  1  hold EXEC slot (datapath not ready to retire)
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address (= PC)
imem_ready  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  registered instruction to decoder
instr_valid  out  1  high in EXEC
PC  out  XLEN  address of instr
PC_plus4  out  XLEN  PC+4 (link value)
misalign_trap  out  1  one-cycle pulse on misaligned redirect
trap_pc  out  XLEN  PC of trapping instruction, held until next trap

Behaviour:
- Reset (synchronous, active-high; clk/reset fixed as above): state=IDLE, PC=RESET_VECTOR, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, misalign_trap=0, trap_pc=0. Reset wins over every other input, including mid-fetch or mid-EXEC. Any in-flight fetch is abandoned.
- States: IDLE, FETCH, EXEC.
- IDLE: imem_req=0. Go to FETCH unconditionally next cycle. imem_ready is ignored, so a stale ack after reset is dropped.
- FETCH: imem_req=1, imem_addr=PC, held stable until ready.
  - On imem_ready: instr<=imem_rdata, go to EXEC.
  - Minimum fetch latency is 1 cycle (ready in the first FETCH cycle).
- EXEC: instr_valid=1, imem_req=0. PC_Src/Jump/Jalr/imm/rs1_data are sampled here only.
  - stall=1: remain in EXEC; PC and instr held.
  - stall=0: update PC, go to FETCH.
- Next-PC priority: Jalr > Jump > PC_Src > sequential.
  - Jalr: target=(rs1_data+imm)&~1.
  - Jump, or PC_Src while Branch is taken: target=PC+imm.
  - Otherwise: PC+4.
  - All additions are modulo 2^XLEN; wrap-around is silent (PC=FFFF_FFFC sequential -> 0000_0000).
- Misalignment: if a redirect target has bits[1:0]!=0:
  - PC<=TRAP_VECTOR, trap_pc<=PC.
  - misalign_trap=1 for exactly the cycle after the EXEC exit.
  - The sequential path never traps.
- PC_plus4 is combinational from PC.
- Throughput: one instruction per 2 cycles minimum (FETCH+EXEC).

Decomposition:
- Shared core package (riscv_pkg): state enum {IDLE,FETCH,EXEC}, NOP constant 32'h0000_0013, XLEN default.
- One natural sub-module: pc_target_gen. It is combinational and takes PC, imm, rs1_data and the selects, and produces next_pc and misaligned.

Test Plan:
- Reset then imem_ready=1 every cycle: imem_addr sequence 0,4,8 with instr_valid alternating 0/1; instr matches imem_rdata.
- Branch taken: PC=0x10, PC_Src=1, imm=0x20 -> next imem_addr=0x30. With PC_Src=1 outside EXEC, the next address is unchanged.
- JALR: rs1_data=0x1003, imm=0x4, Jalr=1, Jump=1, PC_Src=1 -> next PC=0x1006 → misaligned. Expect PC=0x100, trap_pc=old PC, misalign_trap single pulse.
- JAL to aligned: PC=0x40, imm=-8 (0xFFFF_FFF8) -> 0x38.
  - PC=0xFFFF_FFFC sequential -> 0x0, no trap.
- Hold/stall: imem_ready held low 3 cycles -> imem_req and imem_addr stable for 3 cycles. stall=1 for 2 cycles in EXEC -> instr_valid held, PC unchanged.
- Reset asserted during FETCH with ready arriving the next cycle: PC=RESET_VECTOR, instr=NOP, the late ready is ignored, and fetch restarts at 0x0.
